// File: rtl/cache_axi_read_arbiter.sv
// Purpose : merges icache/dcache single-outstanding burst reads onto one AXI4 read channel.
// Latency : request -> m_arvalid 1 cycle; R beats pass through combinationally to the owner.
// Backpr. : m_arready gates the owner's arready; m_rready follows the owner's rready.
// Ports   : clk/rst (async, active-high); i_ar*/i_r* icache side; d_ar*/d_r* dcache side;
//           m_ar*/m_r* AXI master read channel; busy = not idle; proto_err sticky beat-count error.
module cache_axi_read_arbiter #(
    parameter bit         D_FIRST = 1'b1,
    parameter logic [3:0] I_ID    = 4'd0,
    parameter logic [3:0] D_ID    = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [3:0]  d_arlen,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic        busy,
    output logic        proto_err
);

    typedef enum logic [2:0] {IDLE, AR_I, AR_D, R_I, R_D} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 1 = data cache held the last grant
    logic [4:0]  beat_cnt_q, beat_cnt_d;
    logic        proto_err_q, proto_err_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arlen_q, arlen_d;
    logic [3:0]  arid_q, arid_d;
    logic        pick_d;
    logic        beat;

    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arid    = arid_q;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            beat_cnt_q   <= 5'd0;
            proto_err_q  <= 1'b0;
            araddr_q     <= 32'd0;
            arlen_q      <= 4'd0;
            arid_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            proto_err_q  <= proto_err_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arid_q       <= arid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        proto_err_d  = proto_err_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arid_d       = arid_q;
        pick_d       = 1'b0;
        beat         = 1'b0;
        i_arready    = 1'b0;
        d_arready    = 1'b0;
        i_rdata      = 32'd0;
        i_rlast      = 1'b0;
        i_rvalid     = 1'b0;
        d_rdata      = 32'd0;
        d_rlast      = 1'b0;
        d_rvalid     = 1'b0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_arvalid && d_arvalid) begin
                    pick_d = D_FIRST ? 1'b1 : ~last_grant_q;
                end else begin
                    pick_d = d_arvalid;
                end
                if (i_arvalid || d_arvalid) begin
                    if (pick_d) begin
                        state_d  = AR_D;
                        araddr_d = d_araddr;
                        arlen_d  = d_arlen;
                        arid_d   = D_ID;
                    end else begin
                        state_d  = AR_I;
                        araddr_d = i_araddr;
                        arlen_d  = i_arlen;
                        arid_d   = I_ID;
                    end
                end
            end
            AR_I, AR_D: begin
                m_arvalid = 1'b1;
                if (state_q == AR_D) d_arready = m_arready;
                else                 i_arready = m_arready;
                if (m_arready) begin
                    state_d      = (state_q == AR_D) ? R_D : R_I;
                    beat_cnt_d   = 5'd0;
                    last_grant_d = (state_q == AR_D);
                end
            end
            R_I, R_D: begin
                if (state_q == R_D) begin
                    m_rready = d_rready;
                    d_rvalid = m_rvalid;
                    d_rdata  = m_rdata;
                    d_rlast  = m_rlast;
                end else begin
                    m_rready = i_rready;
                    i_rvalid = m_rvalid;
                    i_rdata  = m_rdata;
                    i_rlast  = m_rlast;
                end
                beat = m_rvalid && m_rready;
                if (beat) begin
                    // Saturate so a runaway burst cannot wrap the count back into range.
                    if (beat_cnt_q != 5'd31) beat_cnt_d = beat_cnt_q + 5'd1;
                    // beat_cnt_q counts beats before this one: the last beat must see arlen.
                    if (m_rlast) begin
                        state_d = IDLE;
                        if (beat_cnt_q != {1'b0, arlen_q}) proto_err_d = 1'b1;
                    end else if (beat_cnt_q >= {1'b0, arlen_q}) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
